key_matrix_ctrl: RTL

- Parametrised key-matrix controller that converts decoded PS/2 key events into a ROWS x COLS key matrix and serves row scans from the PPI.
- Events are buffered in an input FIFO and translated through an external multi-layout keymap ROM.
- The matrix is held in a register array, so it can be cleared in a single cycle.
- Sits between the PS/2 decoder and the PPI port B/C logic; it replaces the fixed single-event RAM-based keyboard path.

---
 rtl/kbd_pkg.sv | 23 ++
 rtl/kbd_event_fifo.sv | 48 ++++
 rtl/key_matrix_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2-to-matrix keyboard path: event and keymap
// field positions, FSM states and default matrix geometry.
package kbd_pkg;

  localparam int BRK = 9;
  localparam int EXT = 8;

  localparam int MAP_VALID  = 7;
  localparam int MAP_COL_HI = 6;
  localparam int MAP_COL_LO = 4;
  localparam int MAP_ROW_HI = 3;
  localparam int MAP_ROW_LO = 0;

  localparam int DEF_ROWS = 11;
  localparam int DEF_COLS = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    APPLY
  } kbd_state_t;

endpackage

// File: rtl/kbd_event_fifo.sv
// Small synchronous FIFO for key events; the head word is visible without a pop
// so the consumer can latch it in the same cycle it pops.
module kbd_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  // A push while full is refused even if a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr_reg[AW-1:0]];
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/key_matrix_ctrl.sv
// Turns decoded PS/2 events into a ROWS x COLS key matrix via an external
// keymap ROM and serves registered row reads to the PPI.
module key_matrix_ctrl
  import kbd_pkg::*;
#(
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int NUM_MAPS   = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int MS_W       = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clk_ena,
  input  logic [MS_W-1:0] map_sel,
  input  logic            clear_all,
  input  logic            ev_valid,
  output logic            ev_ready,
  input  logic [9:0]      ev_code,
  output logic [MS_W+8:0] map_addr,
  input  logic [7:0]      map_data,
  input  logic [3:0]      row_sel,
  output logic [COLS-1:0] col_n,
  output logic            any_key,
  output logic            overflow,
  output logic            busy
);

  localparam logic [4:0] ROWS_L = 5'(ROWS);
  localparam logic [3:0] COLS_L = 4'(COLS);

  kbd_state_t      state_reg, state_next;
  logic            cur_brk_reg;
  logic [MS_W+8:0] map_addr_reg;
  logic [MS_W-1:0] map_sel_prev_reg;
  logic            overflow_reg;
  logic [COLS-1:0] col_n_reg;
  logic            any_key_reg;
  logic [COLS-1:0] matrix_reg [ROWS];
  logic [ROWS-1:0] row_any;

  logic       fifo_full, fifo_empty, pop;
  logic [9:0] fifo_head;
  logic       flush, apply_en, write_en, row_ok;
  logic [3:0] map_row;
  logic [2:0] map_col;

  kbd_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (10)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ev_valid),
    .pop   (pop),
    .din   (ev_code),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A layout change invalidates every held key just like an explicit clear.
  assign flush = clear_all || (map_sel != map_sel_prev_reg);

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    apply_en   = 1'b0;
    if (flush) begin
      state_next = IDLE;
    end else if (clk_ena) begin
      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = LOOKUP;
          end
        end
        LOOKUP: state_next = APPLY;
        APPLY: begin
          apply_en   = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      cur_brk_reg  <= 1'b0;
      map_addr_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (pop) begin
        cur_brk_reg  <= fifo_head[BRK];
        map_addr_reg <= {map_sel, fifo_head[EXT], fifo_head[7:0]};
      end
    end
  end

  always_ff @(posedge clk) begin
    map_sel_prev_reg <= map_sel;
    if (reset) overflow_reg <= 1'b0;
    else if (ev_valid && fifo_full) overflow_reg <= 1'b1;
  end

  assign map_row  = map_data[MAP_ROW_HI:MAP_ROW_LO];
  assign map_col  = map_data[MAP_COL_HI:MAP_COL_LO];
  assign write_en = apply_en && map_data[MAP_VALID] &&
                    ({1'b0, map_row} < ROWS_L) && ({1'b0, map_col} < COLS_L);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int r = 0; r < ROWS; r++) matrix_reg[r] <= '0;
    end else if (write_en) begin
      matrix_reg[map_row][map_col] <= !cur_brk_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_any
      assign row_any[gi] = |matrix_reg[gi];
    end
  endgenerate

  // Read path runs every clock so the PPI never sees a blanked row.
  assign row_ok = ({1'b0, row_sel} < ROWS_L);

  always_ff @(posedge clk) begin
    if (reset) begin
      col_n_reg   <= '1;
      any_key_reg <= 1'b0;
    end else begin
      col_n_reg   <= row_ok ? ~matrix_reg[row_sel] : '1;
      any_key_reg <= |row_any;
    end
  end

  assign ev_ready = !fifo_full;
  assign map_addr = map_addr_reg;
  assign col_n    = col_n_reg;
  assign any_key  = any_key_reg;
  assign overflow = overflow_reg;
  assign busy     = (state_reg != IDLE) || !fifo_empty;

endmodule
